// File: rtl/ahb_sram_sub.sv
// AHB-Lite subordinate in front of a word-organised SRAM: configurable wait states,
// two-cycle ERROR for illegal size, misaligned or out-of-range transfers.
module ahb_sram_sub #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned IdxW = $clog2(MEM_DEPTH);
    localparam logic [32:0] LimitAddr = {1'b0, BASE_ADDR} + (33'(MEM_DEPTH) << 2);

    typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              write_q;

    logic [31:0]       mem [MEM_DEPTH];

    logic              sample_en;
    logic              accept;
    logic              legal;
    logic              size_ok;
    logic              align_ok;
    logic              range_ok;
    logic [32:0]       offset;
    logic [3:0]        byte_en;
    logic              unused_in;

    // Only states that drive HREADYOUT = 1 may see a new address phase.
    assign sample_en = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
    assign accept    = sample_en && HSEL && HREADY && HTRANS[1];

    assign offset    = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign size_ok   = (HSIZE <= 3'd2);
    assign align_ok  = !((HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00));
    assign range_ok  = ({1'b0, HADDR} >= {1'b0, BASE_ADDR}) && ({1'b0, HADDR} < LimitAddr);
    assign legal     = size_ok && align_ok && range_ok;

    assign unused_in = ^{HBURST, HPROT, HMASTLOCK, offset[32:IdxW+2], offset[1:0]};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            size_q  <= 2'b00;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= offset[IdxW+1:2];
                lane_q  <= HADDR[1:0];
                size_q  <= HSIZE[1:0];
                write_q <= HWRITE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StData, StErr2: begin
                if (!accept) begin
                    state_d = StIdle;
                end else if (!legal) begin
                    state_d = StErr1;
                end else if (WAIT_STATES > 0) begin
                    state_d = StWait;
                    cnt_d   = 4'(WAIT_STATES - 1);
                end else begin
                    state_d = StData;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        unique case (size_q)
            2'd0:    byte_en = 4'b0001 << lane_q;
            2'd1:    byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Array is deliberately outside the reset domain; contents survive HRESET.
    always_ff @(posedge HCLK) begin
        if (!HRESET && state_q == StData && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'h0;
        unique case (state_q)
            StWait: HREADYOUT = 1'b0;
            StData: HRDATA    = mem[idx_q];
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            StErr2: HRESP     = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_sram_sub.sv
// Bench for ahb_sram_sub: three instances (0, 3 and 2 wait states) on a shared bus,
// driven by a pipelined beat engine and checked against a word-array reference model.
module tb_ahb_sram_sub;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 64;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    logic        clk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [2:0]  hburst = '0;
    logic [3:0]  hprot = 4'b0011;
    logic [1:0]  htrans = '0;
    logic        hmastlock = 1'b0;
    logic [31:0] hwdata = '0;
    logic [1:0]  cur = 2'd0;

    logic [2:0]  hreadyout_v;
    logic [2:0]  hresp_v;
    logic [31:0] hrdata_v [3];
    logic        hready_bus;
    logic        hresp_bus;
    logic [31:0] hrdata_bus;

    assign hready_bus = hreadyout_v[cur];
    assign hresp_bus  = hresp_v[cur];
    assign hrdata_bus = hrdata_v[cur];

    always #5 clk = ~clk;

    ahb_sram_sub #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel && cur == 2'd0), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HMASTLOCK(hmastlock), .HREADY(hready_bus), .HWDATA(hwdata),
        .HRDATA(hrdata_v[0]), .HREADYOUT(hreadyout_v[0]), .HRESP(hresp_v[0])
    );
    ahb_sram_sub #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_dut1 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel && cur == 2'd1), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HMASTLOCK(hmastlock), .HREADY(hready_bus), .HWDATA(hwdata),
        .HRDATA(hrdata_v[1]), .HREADYOUT(hreadyout_v[1]), .HRESP(hresp_v[1])
    );
    ahb_sram_sub #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(2)) u_dut2 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel && cur == 2'd2), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HMASTLOCK(hmastlock), .HREADY(hready_bus), .HWDATA(hwdata),
        .HRDATA(hrdata_v[2]), .HREADYOUT(hreadyout_v[2]), .HRESP(hresp_v[2])
    );

    int          n_checks = 0;
    int          n_fail = 0;
    beat_t       bq[$];
    logic [31:0] mdl [3][DEPTH];
    int          exp_stall [512];
    logic        exp_resp [512];
    logic        exp_err [512];
    logic        exp_chk [512];
    logic [31:0] exp_rdata [512];
    int          obs_stall [512];
    logic        obs_resp [512];
    logic        obs_err [512];
    logic [31:0] obs_rdata [512];

    function automatic int ws_of(logic [1:0] k);
        return (k == 2'd0) ? 0 : (k == 2'd1) ? 3 : 2;
    endfunction

    function automatic bit legal(logic [2:0] s, logic [31:0] a);
        longint la = longint'(a);
        if (s > 3'd2) return 0;
        if (s == 3'd1 && a[0]) return 0;
        if (s == 3'd2 && a[1:0] != 2'b00) return 0;
        if (la < longint'(BASE) || la >= longint'(BASE) + 4 * DEPTH) return 0;
        return 1;
    endfunction

    function automatic void push(bit sel, logic [1:0] tr, bit wr, logic [2:0] sz,
                                 logic [31:0] a, logic [31:0] wd);
        beat_t b;
        b.sel = sel; b.trans = tr; b.write = wr; b.size = sz; b.addr = a; b.wdata = wd;
        bq.push_back(b);
    endfunction

    // Walk the beats in bus order and derive every data-phase response from the rules.
    task automatic predict();
        int ws = ws_of(cur);
        for (int j = 0; j < bq.size(); j++) begin
            beat_t b;
            int    idx;
            int    off;
            bit    lane_hit;
            b = bq[j];
            exp_stall[j] = 0; exp_resp[j] = 0; exp_err[j] = 0; exp_chk[j] = 1; exp_rdata[j] = 0;
            if (b.sel && b.trans[1]) begin
                if (!legal(b.size, b.addr)) begin
                    exp_stall[j] = 1; exp_resp[j] = 1; exp_err[j] = 1;
                end else begin
                    idx = int'((b.addr - BASE) / 4);
                    off = int'(b.addr % 4);
                    exp_stall[j] = ws;
                    if (b.write) begin
                        exp_chk[j] = 0;
                        for (int l = 0; l < 4; l++) begin
                            lane_hit = (b.size == 3'd2) || (b.size == 3'd0 && l == off) ||
                                       (b.size == 3'd1 && l / 2 == off / 2);
                            if (lane_hit) mdl[cur][idx][8*l +: 8] = b.wdata[8*l +: 8];
                        end
                    end else begin
                        exp_rdata[j] = mdl[cur][idx];
                    end
                end
            end
        end
    endtask

    // Pipelined driver: address phase of beat i overlaps the data phase of beat i-1.
    task automatic run_beats();
        int n = bq.size();
        int i = 0;
        int dp = -1;
        int budget = 20 * n + 50;
        bit rdy;
        for (int j = 0; j < n; j++) begin
            obs_stall[j] = 0; obs_err[j] = 0; obs_resp[j] = 0; obs_rdata[j] = '0;
        end
        while ((i < n || dp >= 0) && budget > 0) begin
            if (i < n) begin
                hsel = bq[i].sel; htrans = bq[i].trans; hwrite = bq[i].write;
                hsize = bq[i].size; haddr = bq[i].addr; hburst = 3'($urandom_range(0, 7));
            end else begin
                hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; haddr = '0;
            end
            hwdata = (dp >= 0) ? bq[dp].wdata : 32'h0;
            @(negedge clk);
            rdy = hready_bus;
            if (dp >= 0) begin
                if (!rdy) begin
                    obs_stall[dp]++;
                    if (hresp_bus) obs_err[dp] = 1'b1;
                end else begin
                    obs_resp[dp] = hresp_bus;
                    obs_rdata[dp] = hrdata_bus;
                end
            end
            @(posedge clk);
            #1;
            if (rdy) begin
                if (i < n) begin
                    dp = i;
                    i++;
                end else begin
                    dp = -1;
                end
            end
            budget--;
        end
        if (i < n || dp >= 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_beats timeout: dut %0d got beat %0d of %0d required all", cur, i, n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks += 3;
            if (hreadyout_v[k] !== 1'b1) begin
                n_fail++; $display("FAIL reset_hreadyout dut%0d got %b want 1", k, hreadyout_v[k]);
            end
            if (hresp_v[k] !== 1'b0) begin
                n_fail++; $display("FAIL reset_hresp dut%0d got %b want 0", k, hresp_v[k]);
            end
            if (hrdata_v[k] !== 32'h0) begin
                n_fail++; $display("FAIL reset_hrdata dut%0d got %h want 0", k, hrdata_v[k]);
            end
        end
        @(posedge clk);
        #1;
        hreset = 1'b0;
    endtask

    task automatic test_fill();
        for (int k = 0; k < 3; k++) begin
            cur = 2'(k);
            bq.delete();
            for (int w = 0; w < DEPTH; w++) push(1, 2'b10, 1, 3'd2, BASE + 32'(4 * w), $urandom);
            predict();
            run_beats();
            for (int j = 0; j < bq.size(); j++) begin
                n_checks += 2;
                if (obs_stall[j] !== exp_stall[j]) begin
                    n_fail++; $display("FAIL fill_stall dut%0d beat %0d got %0d want %0d", k, j, obs_stall[j], exp_stall[j]);
                end
                if (obs_resp[j] !== exp_resp[j]) begin
                    n_fail++; $display("FAIL fill_resp dut%0d beat %0d got %b want %b", k, j, obs_resp[j], exp_resp[j]);
                end
            end
        end
    endtask

    task automatic test_word_and_byte();
        cur = 2'd0;
        bq.delete();
        push(1, 2'b10, 1, 3'd2, BASE + 32'h10, 32'hDEAD_BEEF);
        push(1, 2'b10, 0, 3'd2, BASE + 32'h10, 32'h0);
        push(1, 2'b10, 1, 3'd0, BASE + 32'h11, 32'hA5A5_A5A5);
        push(1, 2'b10, 0, 3'd2, BASE + 32'h10, 32'h0);
        predict();
        run_beats();
        n_checks += 2;
        if (obs_rdata[1] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL word_read got %h want deadbeef", obs_rdata[1]);
        end
        if (obs_rdata[3] !== 32'hDEAD_A5EF) begin
            n_fail++; $display("FAIL byte_merge got %h want deada5ef", obs_rdata[3]);
        end
        for (int j = 0; j < bq.size(); j++) begin
            n_checks += 2;
            if (obs_stall[j] !== 0) begin
                n_fail++; $display("FAIL word_byte_stall beat %0d got %0d want 0", j, obs_stall[j]);
            end
            if (obs_resp[j] !== 1'b0) begin
                n_fail++; $display("FAIL word_byte_resp beat %0d got %b want 0", j, obs_resp[j]);
            end
        end
    endtask

    task automatic test_wait_states();
        cur = 2'd1;
        bq.delete();
        push(1, 2'b10, 0, 3'd2, BASE + 32'h40, 32'h0);
        push(1, 2'b10, 1, 3'd1, BASE + 32'h42, 32'h1234_5678);
        push(1, 2'b11, 0, 3'd2, BASE + 32'h40, 32'h0);
        predict();
        run_beats();
        n_checks++;
        if (obs_stall[0] !== 3) begin
            n_fail++; $display("FAIL wait_count got %0d want 3", obs_stall[0]);
        end
        for (int j = 0; j < bq.size(); j++) begin
            n_checks += 3;
            if (obs_stall[j] !== exp_stall[j]) begin
                n_fail++; $display("FAIL wait_stall beat %0d got %0d want %0d", j, obs_stall[j], exp_stall[j]);
            end
            if (obs_resp[j] !== exp_resp[j] || obs_err[j] !== exp_err[j]) begin
                n_fail++; $display("FAIL wait_resp beat %0d got %b/%b want %b/%b", j, obs_resp[j], obs_err[j], exp_resp[j], exp_err[j]);
            end
            if (exp_chk[j] && obs_rdata[j] !== exp_rdata[j]) begin
                n_fail++; $display("FAIL wait_rdata beat %0d got %h want %h", j, obs_rdata[j], exp_rdata[j]);
            end
        end
    endtask

    task automatic test_errors();
        for (int k = 0; k < 2; k++) begin
            cur = 2'(k);
            bq.delete();
            push(1, 2'b10, 0, 3'd2, BASE + 32'h2, 32'h0);
            push(1, 2'b00, 0, 3'd2, BASE, 32'h0);
            push(1, 2'b10, 0, 3'd2, BASE + 32'(4 * DEPTH), 32'h0);
            push(1, 2'b10, 1, 3'd2, BASE + 32'h12, 32'hFFFF_FFFF);
            push(1, 2'b10, 1, 3'd1, BASE + 32'h11, 32'hFFFF_FFFF);
            push(1, 2'b10, 1, 3'd3, BASE + 32'h10, 32'hFFFF_FFFF);
            push(1, 2'b10, 1, 3'd2, BASE - 32'h4, 32'hFFFF_FFFF);
            push(1, 2'b10, 0, 3'd2, BASE + 32'h10, 32'h0);
            predict();
            run_beats();
            if (k == 0) begin
                n_checks++;
                if (obs_rdata[7] !== 32'hDEAD_A5EF) begin
                    n_fail++; $display("FAIL err_mem_unchanged got %h want deada5ef", obs_rdata[7]);
                end
            end
            for (int j = 0; j < bq.size(); j++) begin
                n_checks += 3;
                if (obs_stall[j] !== exp_stall[j]) begin
                    n_fail++; $display("FAIL err_stall dut%0d beat %0d got %0d want %0d", k, j, obs_stall[j], exp_stall[j]);
                end
                if (obs_resp[j] !== exp_resp[j] || obs_err[j] !== exp_err[j]) begin
                    n_fail++; $display("FAIL err_resp dut%0d beat %0d got %b/%b want %b/%b", k, j, obs_resp[j], obs_err[j], exp_resp[j], exp_err[j]);
                end
                if (exp_chk[j] && obs_rdata[j] !== exp_rdata[j]) begin
                    n_fail++; $display("FAIL err_rdata dut%0d beat %0d got %h want %h", k, j, obs_rdata[j], exp_rdata[j]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k += 2) begin
            logic [31:0] wv;
            wv = $urandom;
            cur = 2'(k);
            bq.delete();
            push(1, 2'b10, 1, 3'd2, BASE + 32'h20, wv);
            push(1, 2'b10, 0, 3'd2, BASE + 32'h20, 32'h0);
            push(1, 2'b00, 0, 3'd2, BASE + 32'h20, 32'h0);
            push(1, 2'b01, 0, 3'd2, BASE + 32'h20, 32'h0);
            push(0, 2'b10, 0, 3'd2, BASE + 32'h20, 32'h0);
            push(1, 2'b00, 0, 3'd0, BASE, 32'h0);
            predict();
            run_beats();
            n_checks++;
            if (obs_rdata[1] !== wv) begin
                n_fail++; $display("FAIL b2b_hazard dut%0d got %h want %h", k, obs_rdata[1], wv);
            end
            for (int j = 0; j < bq.size(); j++) begin
                n_checks += 3;
                if (obs_stall[j] !== exp_stall[j]) begin
                    n_fail++; $display("FAIL b2b_stall dut%0d beat %0d got %0d want %0d", k, j, obs_stall[j], exp_stall[j]);
                end
                if (obs_resp[j] !== exp_resp[j]) begin
                    n_fail++; $display("FAIL b2b_resp dut%0d beat %0d got %b want %b", k, j, obs_resp[j], exp_resp[j]);
                end
                if (exp_chk[j] && obs_rdata[j] !== exp_rdata[j]) begin
                    n_fail++; $display("FAIL b2b_rdata dut%0d beat %0d got %h want %h", k, j, obs_rdata[j], exp_rdata[j]);
                end
            end
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] old;
        cur = 2'd2;
        old = mdl[2][12];
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = BASE + 32'h30;
        @(posedge clk);
        #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hwdata = ~old;
        @(negedge clk);
        n_checks++;
        if (hready_bus !== 1'b0) begin
            n_fail++; $display("FAIL rstwait_in_wait hreadyout got %b want 0", hready_bus);
        end
        hreset = 1'b1;
        @(posedge clk);
        #1;
        n_checks += 3;
        if (hready_bus !== 1'b1) begin
            n_fail++; $display("FAIL rstwait_hreadyout got %b want 1", hready_bus);
        end
        if (hresp_bus !== 1'b0) begin
            n_fail++; $display("FAIL rstwait_hresp got %b want 0", hresp_bus);
        end
        if (hrdata_bus !== 32'h0) begin
            n_fail++; $display("FAIL rstwait_hrdata got %h want 0", hrdata_bus);
        end
        hreset = 1'b0;
        hwdata = '0;
        bq.delete();
        push(1, 2'b10, 0, 3'd2, BASE + 32'h30, 32'h0);
        predict();
        run_beats();
        n_checks += 2;
        if (obs_rdata[0] !== old) begin
            n_fail++; $display("FAIL rstwait_mem got %h want %h", obs_rdata[0], old);
        end
        if (obs_stall[0] !== 2) begin
            n_fail++; $display("FAIL rstwait_stall got %0d want 2", obs_stall[0]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            cur = 2'(k);
            bq.delete();
            for (int j = 0; j < 80; j++) begin
                logic [2:0]  sz;
                logic [31:0] a;
                logic [1:0]  tr;
                int          r;
                sz = ($urandom_range(0, 9) == 9) ? 3'd3 : 3'($urandom_range(0, 2));
                r = $urandom_range(0, 19);
                if (r == 0) a = BASE - 32'($urandom_range(1, 16));
                else if (r == 1) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
                else a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
                if ($urandom_range(0, 1) == 1 && sz == 3'd1) a[0] = 1'b0;
                if ($urandom_range(0, 1) == 1 && sz == 3'd2) a[1:0] = 2'b00;
                tr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
                push($urandom_range(0, 7) != 0, tr, 1'($urandom_range(0, 1)), sz, a, $urandom);
            end
            predict();
            run_beats();
            for (int j = 0; j < bq.size(); j++) begin
                n_checks += 3;
                if (obs_stall[j] !== exp_stall[j]) begin
                    n_fail++; $display("FAIL rand_stall dut%0d beat %0d got %0d want %0d", k, j, obs_stall[j], exp_stall[j]);
                end
                if (obs_resp[j] !== exp_resp[j] || obs_err[j] !== exp_err[j]) begin
                    n_fail++; $display("FAIL rand_resp dut%0d beat %0d got %b/%b want %b/%b", k, j, obs_resp[j], obs_err[j], exp_resp[j], exp_err[j]);
                end
                if (exp_chk[j] && obs_rdata[j] !== exp_rdata[j]) begin
                    n_fail++; $display("FAIL rand_rdata dut%0d beat %0d got %h want %h", k, j, obs_rdata[j], exp_rdata[j]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_word_and_byte();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
